// File: rtl/multicycle_control_if.sv
// Control/datapath bundle of the multicycle RV32I controller: decoded IR fields and status in, datapath strobes and mux selects out.
interface multicycle_control_if #(parameter int ULA_W = 5, parameter int STATE_W = 4);
  logic [6:0]         iOpcode;
  logic [2:0]         iFunct3;
  logic               iFunct7b5;
  logic               iZero;
  logic               iMemReady;
  logic               oPCWrite;
  logic               oIRWrite;
  logic               oIorD;
  logic               oMemRead;
  logic               oMemWrite;
  logic               oRegWrite;
  logic [2:0]         oMem2Reg;
  logic [2:0]         oOrigPC;
  logic [1:0]         oOrigAULA;
  logic [1:0]         oOrigBULA;
  logic [ULA_W-1:0]   oULAControl;
  logic               oInstRetired;
  logic               oTrap;
  logic [STATE_W-1:0] oState;

  modport master (
    input  iOpcode, iFunct3, iFunct7b5, iZero, iMemReady,
    output oPCWrite, oIRWrite, oIorD, oMemRead, oMemWrite, oRegWrite, oMem2Reg,
           oOrigPC, oOrigAULA, oOrigBULA, oULAControl, oInstRetired, oTrap, oState
  );

  modport slave (
    output iOpcode, iFunct3, iFunct7b5, iZero, iMemReady,
    input  oPCWrite, oIRWrite, oIorD, oMemRead, oMemWrite, oRegWrite, oMem2Reg,
           oOrigPC, oOrigAULA, oOrigBULA, oULAControl, oInstRetired, oTrap, oState
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM driving a shared datapath with one unified memory port.
// Optional feature: define ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module multicycle_control #(
  parameter int ULA_W   = 5,
  parameter int STATE_W = 4
) (
  input logic                 iCLK,
  input logic                 iRST,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  EXEC_I = 4'd3,
    MEM_ADDR = 4'd4,  MEM_RD = 4'd5,  MEM_WB = 4'd6,  MEM_WR = 4'd7,
    BRANCH   = 4'd8,  JAL    = 4'd9,  JALR   = 4'd10, LUI    = 4'd11,
    AUIPC    = 4'd12, ALU_WB = 4'd13, TRAP   = 4'd14
  } stateT;

  localparam logic [4:0] ULA_AND = 5'd0, ULA_OR  = 5'd1, ULA_ADD = 5'd2, ULA_XOR  = 5'd3,
                         ULA_SLL = 5'd4, ULA_SRL = 5'd5, ULA_SUB = 5'd6, ULA_SLT  = 5'd7,
                         ULA_SLTU = 5'd8, ULA_SRA = 5'd9;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

  stateT state;
  stateT decodeNext;
  logic  running;
  logic  branchTaken;
  logic  retireInDecode;
  logic [4:0] ulaOp;

  function automatic logic [4:0] aluOp(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ULA_SUB : ULA_ADD;
      3'b001:  op = ULA_SLL;
      3'b010:  op = ULA_SLT;
      3'b011:  op = ULA_SLTU;
      3'b100:  op = ULA_XOR;
      3'b101:  op = alt ? ULA_SRA : ULA_SRL;
      3'b110:  op = ULA_OR;
      default: op = ULA_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    decodeNext     = FETCH;
    retireInDecode = 1'b0;
    case (bus.iOpcode)
      OP_R:                decodeNext = EXEC_R;
      OP_I:                decodeNext = EXEC_I;
      OP_LOAD, OP_STORE:   decodeNext = MEM_ADDR;
      OP_BRANCH:           decodeNext = BRANCH;
      OP_JAL:              decodeNext = JAL;
      OP_JALR:             decodeNext = JALR;
      OP_LUI:              decodeNext = LUI;
      OP_AUIPC:            decodeNext = AUIPC;
      OP_FENCE, OP_SYSTEM: retireInDecode = 1'b1;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        decodeNext = TRAP;
`else
        retireInDecode = 1'b1;
`endif
      end
    endcase
  end

  // beq/bge/bgeu take on a zero result, bne/blt/bltu on non-zero; funct3 010/011 never take
  always_comb begin
    case (bus.iFunct3)
      3'b000, 3'b101, 3'b111: branchTaken = bus.iZero;
      3'b001, 3'b100, 3'b110: branchTaken = !bus.iZero;
      default:                branchTaken = 1'b0;
    endcase
  end

  // running stays low for the first cycle after reset so every output reads 0 until released
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state   <= FETCH;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (running) begin
        case (state)
          FETCH:                     if (bus.iMemReady) state <= DECODE;
          DECODE:                    state <= decodeNext;
          EXEC_R, EXEC_I, LUI, AUIPC: state <= ALU_WB;
          MEM_ADDR:                  state <= (bus.iOpcode == OP_LOAD) ? MEM_RD : MEM_WR;
          MEM_RD:                    if (bus.iMemReady) state <= MEM_WB;
          MEM_WR:                    if (bus.iMemReady) state <= FETCH;
          TRAP:                      state <= TRAP;
          default:                   state <= FETCH;
        endcase
      end
    end
  end

  always_comb begin
    bus.oPCWrite     = 1'b0;
    bus.oIRWrite     = 1'b0;
    bus.oIorD        = 1'b0;
    bus.oMemRead     = 1'b0;
    bus.oMemWrite    = 1'b0;
    bus.oRegWrite    = 1'b0;
    bus.oMem2Reg     = 3'd0;
    bus.oOrigPC      = 3'd0;
    bus.oOrigAULA    = 2'd0;
    bus.oOrigBULA    = 2'd0;
    bus.oInstRetired = 1'b0;
    ulaOp            = ULA_AND;
    if (running) begin
      case (state)
        FETCH: begin
          bus.oMemRead  = 1'b1;
          bus.oOrigAULA = 2'd3;
          bus.oOrigBULA = 2'd2;
          ulaOp         = ULA_ADD;
          bus.oIRWrite  = bus.iMemReady;
          bus.oPCWrite  = bus.iMemReady;
        end
        DECODE: begin
          bus.oOrigBULA    = 2'd1;
          ulaOp            = ULA_ADD;
          bus.oInstRetired = retireInDecode;
        end
        EXEC_R: begin
          bus.oOrigAULA = 2'd1;
          ulaOp         = aluOp(bus.iFunct3, bus.iFunct7b5);
        end
        EXEC_I: begin
          bus.oOrigAULA = 2'd1;
          bus.oOrigBULA = 2'd1;
          ulaOp         = aluOp(bus.iFunct3, bus.iFunct7b5 && (bus.iFunct3 == 3'b101));
        end
        LUI: begin
          bus.oOrigAULA = 2'd2;
          bus.oOrigBULA = 2'd1;
          ulaOp         = ULA_ADD;
        end
        AUIPC: begin
          bus.oOrigBULA = 2'd1;
          ulaOp         = ULA_ADD;
        end
        ALU_WB: begin
          bus.oRegWrite    = 1'b1;
          bus.oInstRetired = 1'b1;
        end
        MEM_ADDR: begin
          bus.oOrigAULA = 2'd1;
          bus.oOrigBULA = 2'd1;
          ulaOp         = ULA_ADD;
        end
        MEM_RD: begin
          bus.oMemRead = 1'b1;
          bus.oIorD    = 1'b1;
        end
        MEM_WB: begin
          bus.oRegWrite    = 1'b1;
          bus.oMem2Reg     = 3'd1;
          bus.oInstRetired = 1'b1;
        end
        MEM_WR: begin
          bus.oMemWrite    = 1'b1;
          bus.oIorD        = 1'b1;
          bus.oInstRetired = bus.iMemReady;
        end
        BRANCH: begin
          bus.oOrigAULA    = 2'd1;
          ulaOp            = (bus.iFunct3[2:1] == 2'b10) ? ULA_SLT :
                             (bus.iFunct3[2:1] == 2'b11) ? ULA_SLTU : ULA_SUB;
          bus.oPCWrite     = branchTaken;
          bus.oOrigPC      = 3'd1;
          bus.oInstRetired = 1'b1;
        end
        JAL: begin
          bus.oPCWrite     = 1'b1;
          bus.oOrigPC      = 3'd1;
          bus.oRegWrite    = 1'b1;
          bus.oMem2Reg     = 3'd2;
          bus.oInstRetired = 1'b1;
        end
        JALR: begin
          bus.oOrigAULA    = 2'd1;
          bus.oOrigBULA    = 2'd1;
          ulaOp            = ULA_ADD;
          bus.oPCWrite     = 1'b1;
          bus.oOrigPC      = 3'd2;
          bus.oRegWrite    = 1'b1;
          bus.oMem2Reg     = 3'd2;
          bus.oInstRetired = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.oULAControl = ULA_W'(ulaOp);
  assign bus.oState      = STATE_W'(state);
`ifdef ILLEGAL_TRAP_EN
  assign bus.oTrap = running && (state == TRAP);
`else
  assign bus.oTrap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction reference model (latency, strobe counts, ULA op) plus corner sequences.
module tb_multicycle_control;
  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  multicycle_control_if bus();
  multicycle_control dut(.iCLK(iCLK), .iRST(iRST), .bus(bus));

  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    int cycles; int retires; int regW; int regWAt; int memW; int memR; int dataAcc;
    int lastPc; int lastOrigPC; int mem2Reg; int ulaExec; int irAtFetch; int trap;
    int st[16];
  } obsT;

  typedef struct {
    int lat; int regW; int memW; int memR; int pcLast; int origPC; int mem2Reg; int ula;
  } expT;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic z; int lat; int ula; int pc;
  } vecT;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Architectural ULA op for an ALU instruction, from the RV32I funct3 meaning
  function automatic int aluRef(input int f3, input bit alt);
    int names[8];
    names = '{2, 4, 7, 8, 3, 5, 1, 0};
    if (alt && f3 == 0) return 6;
    if (alt && f3 == 5) return 9;
    return names[f3];
  endfunction

  function automatic expT model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic z, input int fw, input int mw);
    expT e;
    bit taken;
    e = '{lat:2, regW:0, memW:0, memR:fw+1, pcLast:0, origPC:0, mem2Reg:0, ula:-1};
    taken = (f3 inside {3'd0, 3'd5, 3'd7}) ? z : (f3 inside {3'd1, 3'd4, 3'd6}) ? !z : 1'b0;
    case (op)
      7'b0110011: begin e.lat = 4; e.regW = 1; e.ula = aluRef(f3, f7); end
      7'b0010011: begin e.lat = 4; e.regW = 1; e.ula = aluRef(f3, f7 && f3 == 3'd5); end
      7'b0110111, 7'b0010111: begin e.lat = 4; e.regW = 1; e.ula = 2; end
      7'b0000011: begin e.lat = 5 + mw; e.regW = 1; e.mem2Reg = 1; e.memR += mw + 1; e.ula = 2; end
      7'b0100011: begin e.lat = 4 + mw; e.memW = mw + 1; e.ula = 2; end
      7'b1100011: begin
        e.lat = 3; e.pcLast = taken; e.origPC = 1;
        e.ula = (f3 <= 3'd1) ? 6 : (f3 inside {3'd4, 3'd5}) ? 7 : (f3 >= 3'd6) ? 8 : -1;
      end
      7'b1101111: begin e.lat = 3; e.regW = 1; e.mem2Reg = 2; e.pcLast = 1; e.origPC = 1; end
      7'b1100111: begin e.lat = 3; e.regW = 1; e.mem2Reg = 2; e.pcLast = 1; e.origPC = 2; e.ula = 2; end
      default: e.lat = 2;
    endcase
    e.lat += fw;
    return e;
  endfunction

  // Memory is not ready for the first fw fetch cycles and for the first mw cycles of a data access
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic z, input int fw, input int mw, output obsT o);
    o = '{default:0};
    o.mem2Reg = -1;
    o.ulaExec = -1;
    o.cycles  = 40;
    for (int c = 0; c < 40; c++) begin
      @(negedge iCLK);
      if (c == 0) begin
        bus.iOpcode = op; bus.iFunct3 = f3; bus.iFunct7b5 = f7; bus.iZero = z;
      end
      bus.iMemReady = !((c < fw) || (c >= fw + 3 && c < fw + 3 + mw));
      #1;
      if (c < 16) o.st[c] = int'(bus.oState);
      o.regW += int'(bus.oRegWrite);
      o.memW += int'(bus.oMemWrite);
      o.memR += int'(bus.oMemRead);
      if (bus.oRegWrite) begin o.mem2Reg = int'(bus.oMem2Reg); o.regWAt = c + 1; end
      if (bus.oMemRead && bus.oIorD) o.dataAcc++;
      if (c == fw) o.irAtFetch = int'(bus.oIRWrite);
      if (c == fw + 2) o.ulaExec = int'(bus.oULAControl);
      o.trap |= int'(bus.oTrap);
      if (bus.oInstRetired) begin
        o.cycles = c + 1; o.retires = 1;
        o.lastPc = int'(bus.oPCWrite); o.lastOrigPC = int'(bus.oOrigPC);
        return;
      end
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int fw, input int mw);
    obsT o;
    expT e;
    e = model(op, f3, f7, z, fw, mw);
    applyStimulus(op, f3, f7, z, fw, mw, o);
    checkOutput({tag, " latency"}, o.cycles, e.lat);
    checkOutput({tag, " retired"}, o.retires, 1);
    checkOutput({tag, " regWrites"}, o.regW, e.regW);
    checkOutput({tag, " memWrites"}, o.memW, e.memW);
    checkOutput({tag, " memReads"}, o.memR, e.memR);
    checkOutput({tag, " irWrite"}, o.irAtFetch, 1);
    checkOutput({tag, " pcWriteLast"}, o.lastPc, e.pcLast);
    checkOutput({tag, " trap"}, o.trap, 0);
    if (e.pcLast != 0) checkOutput({tag, " origPC"}, o.lastOrigPC, e.origPC);
    if (e.regW != 0) checkOutput({tag, " mem2Reg"}, o.mem2Reg, e.mem2Reg);
    if (e.ula >= 0) checkOutput({tag, " ula"}, o.ulaExec, e.ula);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecT vecs[13];
    logic [6:0] ops[10];
    obsT o;

    bus.iOpcode = 7'd0; bus.iFunct3 = 3'd0; bus.iFunct7b5 = 1'b0;
    bus.iZero = 1'b0; bus.iMemReady = 1'b1;

    vecs = '{
      '{7'b0010011, 3'd0, 1'b0, 1'b0, 4, 2, 0},   // addi
      '{7'b0110011, 3'd0, 1'b1, 1'b0, 4, 6, 0},   // sub
      '{7'b0010011, 3'd5, 1'b1, 1'b0, 4, 9, 0},   // srai
      '{7'b0010011, 3'd0, 1'b1, 1'b0, 4, 2, 0},   // addi with bit30 set stays ADD
      '{7'b0110011, 3'd3, 1'b0, 1'b0, 4, 8, 0},   // sltu
      '{7'b1100011, 3'd0, 1'b0, 1'b1, 3, 6, 1},   // beq taken
      '{7'b1100011, 3'd1, 1'b0, 1'b1, 3, 6, 0},   // bne not taken
      '{7'b1100011, 3'd4, 1'b0, 1'b0, 3, 7, 1},   // blt taken
      '{7'b1100011, 3'd7, 1'b0, 1'b0, 3, 8, 0},   // bgeu not taken
      '{7'b1100111, 3'd0, 1'b0, 1'b0, 3, 2, 1},   // jalr
      '{7'b1101111, 3'd0, 1'b0, 1'b0, 3, -1, 1},  // jal
      '{7'b0110111, 3'd0, 1'b0, 1'b0, 4, 2, 0},   // lui
      '{7'b0001111, 3'd0, 1'b0, 1'b0, 2, -1, 0}   // fence
    };
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

    repeat (2) @(posedge iCLK);
    @(negedge iCLK); #1;
    checkOutput("reset state", int'(bus.oState), 0);
    checkOutput("reset memRead", int'(bus.oMemRead), 0);
    checkOutput("reset irWrite", int'(bus.oIRWrite), 0);
    checkOutput("reset pcWrite", int'(bus.oPCWrite), 0);
    checkOutput("reset origA", int'(bus.oOrigAULA), 0);
    checkOutput("reset ula", int'(bus.oULAControl), 0);
    checkOutput("reset retire", int'(bus.oInstRetired), 0);
    checkOutput("reset trap", int'(bus.oTrap), 0);
    iRST = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, 0, 0, o);
      checkOutput($sformatf("vec%0d latency", i), o.cycles, vecs[i].lat);
      checkOutput($sformatf("vec%0d pcWriteLast", i), o.lastPc, vecs[i].pc);
      if (vecs[i].ula >= 0) checkOutput($sformatf("vec%0d ula", i), o.ulaExec, vecs[i].ula);
    end

    // addi x1,x0,5 walks FETCH, DECODE, EXEC_I, ALU_WB and writes rd in its fourth cycle
    applyStimulus(7'b0010011, 3'd0, 1'b0, 1'b0, 0, 0, o);
    checkOutput("addi st0", o.st[0], 0);
    checkOutput("addi st1", o.st[1], 1);
    checkOutput("addi st2", o.st[2], 3);
    checkOutput("addi st3", o.st[3], 13);
    checkOutput("addi regWAt", o.regWAt, 4);

    // lw with three wait cycles in MEM_RD
    applyStimulus(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3, o);
    checkOutput("lw latency", o.cycles, 8);
    checkOutput("lw dataReads", o.dataAcc, 4);
    checkOutput("lw regWrites", o.regW, 1);
    checkOutput("lw mem2Reg", o.mem2Reg, 1);

    // reset while a store waits on memory abandons it
    for (int c = 0; c < 4; c++) begin
      @(negedge iCLK);
      if (c == 0) begin bus.iOpcode = 7'b0100011; bus.iFunct3 = 3'd2; end
      bus.iMemReady = (c < 3);
    end
    #1;
    checkOutput("stwait state", int'(bus.oState), 7);
    checkOutput("stwait memWrite", int'(bus.oMemWrite), 1);
    iRST = 1'b0;
    @(negedge iCLK); #1;
    checkOutput("strst memWrite", int'(bus.oMemWrite), 0);
    checkOutput("strst state", int'(bus.oState), 0);
    checkOutput("strst retire", int'(bus.oInstRetired), 0);
    iRST = 1'b1;
    bus.iMemReady = 1'b1;

`ifdef ILLEGAL_TRAP_EN
    for (int c = 0; c < 6; c++) begin
      @(negedge iCLK);
      if (c == 0) bus.iOpcode = 7'b0000000;
      #1;
      checkOutput($sformatf("illegal retire c%0d", c), int'(bus.oInstRetired), 0);
      if (c >= 2) begin
        checkOutput($sformatf("trap state c%0d", c), int'(bus.oState), 14);
        checkOutput($sformatf("trap flag c%0d", c), int'(bus.oTrap), 1);
        checkOutput($sformatf("trap memRead c%0d", c), int'(bus.oMemRead), 0);
      end
    end
    iRST = 1'b0;
    @(negedge iCLK); #1;
    checkOutput("trap cleared", int'(bus.oTrap), 0);
    checkOutput("trap reset state", int'(bus.oState), 0);
    iRST = 1'b1;
`else
    applyStimulus(7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0, o);
    checkOutput("illegal latency", o.cycles, 2);
    checkOutput("illegal retired", o.retires, 1);
    checkOutput("illegal trap", o.trap, 0);
    checkOutput("illegal regWrites", o.regW, 0);
`endif
    runAndCheck("post addi", 7'b0010011, 3'd0, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 50; i++) begin
      runAndCheck($sformatf("rnd%0d", i), ops[$urandom_range(0, 9)],
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
